// File: rtl/mean_pkg.sv
// Shared types and helpers for the parametrised block-mean calculator.
package mean_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_DIV     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

    // Accumulator width that holds N full-scale samples without overflow.
    function automatic int acc_w(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/mean_accum_ctrl.sv
// Block sequencing FSM for mean_accum_param: start, collect, divide, report.
module mean_accum_ctrl
    import mean_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic xfer,
    input  logic last,
    output logic clear,
    output logic acc_en,
    output logic div_en,
    output logic done,
    output logic ready,
    output logic data_ready
);

    state_t state;
    state_t state_next;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_CLEAR;
            ST_CLEAR:   state_next = abort ? ST_IDLE : ST_COLLECT;
            ST_COLLECT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (xfer && last) begin
                    state_next = ST_DIV;
                end
            end
            ST_DIV:     state_next = abort ? ST_IDLE : ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs depend on state alone; the enables may look at inputs
    // because they only steer internal registers.
    assign ready      = (state == ST_IDLE);
    assign data_ready = (state == ST_COLLECT);
    assign done       = (state == ST_DONE);
    assign clear      = (state == ST_CLEAR);
    assign acc_en     = (state == ST_COLLECT) && xfer && !abort;
    assign div_en     = (state == ST_DIV) && !abort;

endmodule

// File: rtl/mean_accum_param.sv
// Accumulates a block of 2^LOG2_N unsigned samples and reports their mean by shift.
module mean_accum_param
    import mean_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] mean,
    output logic              done,
    output logic              ready
);

    localparam int ACC_W = acc_w(DATA_W, LOG2_N);
    localparam int N     = 1 << LOG2_N;
    localparam logic [ACC_W-1:0] RND_ADD =
        (ROUND == RND_HALF_UP) ? ACC_W'(N / 2) : '0;

    logic [ACC_W-1:0]  acc;
    logic [LOG2_N-1:0] count;
    logic [ACC_W-1:0]  rounded;
    logic              xfer;
    logic              last;
    logic              clear;
    logic              acc_en;
    logic              div_en;

    assign xfer = data_valid && data_ready;
    assign last = &count;

    mean_accum_ctrl u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .xfer       (xfer),
        .last       (last),
        .clear      (clear),
        .acc_en     (acc_en),
        .div_en     (div_en),
        .done       (done),
        .ready      (ready),
        .data_ready (data_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
        end else if (clear) begin
            acc   <= '0;
            count <= '0;
        end else if (acc_en) begin
            acc   <= acc + ACC_W'(data_in);
            count <= count + LOG2_N'(1);
        end
    end

    // Sum is bounded by N*(2^DATA_W-1)+N/2, so the top DATA_W bits never wrap.
    assign rounded = acc + RND_ADD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mean <= '0;
        end else if (div_en) begin
            mean <= rounded[ACC_W-1:LOG2_N];
        end
    end

endmodule
